// File: rtl/i2c_arbiter_pkg.sv
// Shared types for the I2C transfer arbiter and its helpers.
package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  typedef struct packed {
    logic       direction;
    logic [7:0] slave_address;
    logic [7:0] register_address;
    logic [7:0] data;
  } i2c_request_t;

  localparam int FIELD_W = 8;

endpackage

// File: rtl/i2c_transfer_arbiter_rr_grant.sv
// Rotating priority encoder: picks the first asserted request at or above
// ptr_i, wrapping past the top back to index 0.
module rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(N);

  logic             found;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] idx;

  // Walk the candidates in priority order starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= NUM_L) begin
        cand = cand - NUM_L;
      end
      idx = cand[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        index_o      = idx;
        found        = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/i2c_transfer_arbiter.sv
// Shares one I2C transfer engine among several requesters with round-robin
// priority, gates the SCL timebase around each transfer and aborts transfers
// whose done never arrives.
module i2c_transfer_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int N_REQUESTERS   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_REQUESTERS-1:0]           req_valid,
  output logic [N_REQUESTERS-1:0]           req_ready,
  input  logic [N_REQUESTERS-1:0]           req_direction,
  input  logic [FIELD_W*N_REQUESTERS-1:0]   req_slave_address,
  input  logic [FIELD_W*N_REQUESTERS-1:0]   req_register_address,
  input  logic [FIELD_W*N_REQUESTERS-1:0]   req_data,
  output logic [N_REQUESTERS-1:0]           rsp_valid,
  output logic                              rsp_timeout,
  output logic                              i2c_start,
  output logic                              i2c_direction,
  output logic [FIELD_W-1:0]                i2c_slave_address,
  output logic [FIELD_W-1:0]                i2c_register_address,
  output logic [FIELD_W-1:0]                i2c_data,
  input  logic                              i2c_done,
  output logic                              i2c_timebase_enable,
  output logic                              busy
);

  localparam int IDX_W = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX     = IDX_W'(N_REQUESTERS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] EXPIRE_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                    state_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          ptr_d;
  logic [IDX_W-1:0]          owner_q;
  logic [TIMEOUT_WIDTH-1:0]  wd_q;
  logic [TIMEOUT_WIDTH-1:0]  wd_d;
  logic                      done_prev_q;
  logic                      done_edge;
  i2c_request_t              fields_q;
  i2c_request_t              sel_d;
  logic                      start_q;
  logic                      tbe_q;
  logic                      busy_q;
  logic [N_REQUESTERS-1:0]   rsp_valid_q;
  logic                      rsp_timeout_q;
  logic [N_REQUESTERS-1:0]   owner_mask;

  logic [N_REQUESTERS-1:0]   grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_any;

  rr_grant #(
    .N     (N_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .index_o (grant_idx),
    .any_o   (grant_any)
  );

  // Only the winning requester's fields reach the capture registers.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (grant[i]) begin
        sel_d.direction        = req_direction[i];
        sel_d.slave_address    = req_slave_address[FIELD_W*i +: FIELD_W];
        sel_d.register_address = req_register_address[FIELD_W*i +: FIELD_W];
        sel_d.data             = req_data[FIELD_W*i +: FIELD_W];
      end
    end
  end

  assign req_ready  = (state_q == IDLE) ? grant : '0;
  assign done_edge  = i2c_done & ~done_prev_q;
  assign wd_d       = wd_q + TIMEOUT_WIDTH'(1);
  assign ptr_d      = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
  assign owner_mask = N_REQUESTERS'(1) << owner_q;

  // Transfer sequencer; the watchdog starts counting in the start-pulse cycle
  // so an abort lands exactly TIMEOUT_CYCLES after the start pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      wd_q          <= '0;
      done_prev_q   <= 1'b0;
      fields_q      <= '0;
      start_q       <= 1'b0;
      tbe_q         <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      done_prev_q   <= i2c_done;
      start_q       <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            fields_q <= sel_d;
            owner_q  <= grant_idx;
            start_q  <= 1'b1;
            tbe_q    <= 1'b1;
            busy_q   <= 1'b1;
            wd_q     <= '0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= wd_d;
          state_q <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_d;
          if (done_edge) begin
            rsp_valid_q   <= owner_mask;
            rsp_timeout_q <= 1'b0;
            tbe_q         <= 1'b0;
            state_q       <= COMPLETE;
          end else if (wd_q == EXPIRE_COUNT) begin
            rsp_valid_q   <= owner_mask;
            rsp_timeout_q <= 1'b1;
            tbe_q         <= 1'b0;
            state_q       <= COMPLETE;
          end
        end
        COMPLETE: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid            = rsp_valid_q;
  assign rsp_timeout          = rsp_timeout_q;
  assign i2c_start            = start_q;
  assign i2c_direction        = fields_q.direction;
  assign i2c_slave_address    = fields_q.slave_address;
  assign i2c_register_address = fields_q.register_address;
  assign i2c_data             = fields_q.data;
  assign i2c_timebase_enable  = tbe_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_i2c_transfer_arbiter.sv
// Scoreboard bench for the I2C transfer arbiter: the stimulus queues the
// expected ready/start/response events with their cycle numbers, and a
// negedge monitor matches every event the DUT presents against that queue.
module tb_i2c_transfer_arbiter;

  localparam int N  = 4;
  localparam int TO = 48;
  localparam int TW = 6;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  vec;
    logic [24:0] fields;
    logic        tmo;
    logic [1:0]  flags;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_direction;
  logic [8*N-1:0] req_slave_address;
  logic [8*N-1:0] req_register_address;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  rsp_valid;
  logic          rsp_timeout;
  logic          i2c_start;
  logic          i2c_direction;
  logic [7:0]    i2c_slave_address;
  logic [7:0]    i2c_register_address;
  logic [7:0]    i2c_data;
  logic          i2c_done;
  logic          i2c_timebase_enable;
  logic          busy;

  int            cyc = 0;
  int            zeroCheckAt = -1;
  int            finalAt = -1;
  int            checkCount = 0;
  int            passCount = 0;
  ev_t           sb[$];
  logic [24:0]   fieldTab [N];

  i2c_transfer_arbiter #(
    .N_REQUESTERS   (N),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_WIDTH  (TW)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_direction        (req_direction),
    .req_slave_address    (req_slave_address),
    .req_register_address (req_register_address),
    .req_data             (req_data),
    .rsp_valid            (rsp_valid),
    .rsp_timeout          (rsp_timeout),
    .i2c_start            (i2c_start),
    .i2c_direction        (i2c_direction),
    .i2c_slave_address    (i2c_slave_address),
    .i2c_register_address (i2c_register_address),
    .i2c_data             (i2c_data),
    .i2c_done             (i2c_done),
    .i2c_timebase_enable  (i2c_timebase_enable),
    .busy                 (busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter used to label every expected and observed event.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    if (k == 0) return "ready";
    if (k == 1) return "start";
    return "rsp";
  endfunction

  // Advance to the given cycle and settle 1ns past its rising edge.
  task automatic goTo(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pushEv(input int kind, input int c, input logic [3:0] vec,
                        input logic [24:0] f, input logic tmo, input logic [1:0] flags);
    ev_t e;
    e.kind = kind; e.cyc = c; e.vec = vec; e.fields = f; e.tmo = tmo; e.flags = flags;
    sb.push_back(e);
  endtask

  // One complete transfer: queue its three events, then drive request and done.
  task automatic applyStimulus(input int idx, input int t, input int doneOn, input int doneOff,
                               input int rspCyc, input logic tmo, input logic hold);
    logic [3:0] v;
    v = 4'b0001 << idx;
    pushEv(0, t, v, 25'h0, 1'b0, 2'b00);
    pushEv(1, t + 1, 4'b0000, fieldTab[idx], 1'b0, 2'b11);
    pushEv(2, rspCyc, v, fieldTab[idx], tmo, 2'b01);
    goTo(t);
    req_valid[idx] = 1'b1;
    goTo(t + 1);
    if (!hold) req_valid[idx] = 1'b0;
    if (doneOn >= 0) begin
      goTo(doneOn);
      i2c_done = 1'b1;
      goTo(doneOff);
      i2c_done = 1'b0;
    end
    goTo(rspCyc + 1);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    goTo(cyc + 1);
    zeroCheckAt = cyc;
    reset = 1'b0;
    goTo(cyc + 1);
  endtask

  task automatic checkOutput();
    logic [48:0] all;
    all = {req_ready, rsp_valid, rsp_timeout, i2c_start, i2c_direction, i2c_slave_address,
           i2c_register_address, i2c_data, i2c_timebase_enable, busy};
    checkCount++;
    if (all == '0) passCount++;
    else $display("[TB] FAIL reset_outputs @cycle %0d: got %h, required 0", cyc, all);
  endtask

  task automatic checkEvent(input int kind);
    ev_t obs;
    ev_t e;
    obs.kind   = kind;
    obs.cyc    = cyc;
    obs.vec    = req_ready | rsp_valid;
    obs.fields = (kind == 0) ? 25'h0
               : {i2c_direction, i2c_slave_address, i2c_register_address, i2c_data};
    obs.tmo    = rsp_timeout;
    obs.flags  = {i2c_timebase_enable, busy};
    checkCount++;
    if (sb.size() == 0 || sb[0].cyc != cyc) begin
      $display("[TB] FAIL unexpected_%s @cycle %0d: got vec=%b, required no event",
               kindName(kind), cyc, obs.vec);
    end else begin
      e = sb.pop_front();
      if (e.kind == obs.kind && e.vec == obs.vec && e.fields == obs.fields &&
          e.tmo == obs.tmo && e.flags == obs.flags) begin
        passCount++;
      end else begin
        $display("[TB] FAIL %s @cycle %0d: got %s vec=%b fields=%h tmo=%b flags=%b, required %s vec=%b fields=%h tmo=%b flags=%b",
                 kindName(e.kind), cyc, kindName(obs.kind), obs.vec, obs.fields, obs.tmo, obs.flags,
                 kindName(e.kind), e.vec, e.fields, e.tmo, e.flags);
      end
    end
  endtask

  // Monitor: expire missed events, match presented events, run reset and final checks.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checkCount++;
      $display("[TB] FAIL missing_%s @cycle %0d: got nothing, required event at cycle %0d",
               kindName(sb[0].kind), cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (cyc == zeroCheckAt) checkOutput();
    if (req_ready != '0) checkEvent(0);
    if (i2c_start) checkEvent(1);
    if (rsp_valid != '0) checkEvent(2);
    if (cyc == finalAt) begin
      while (sb.size() > 0) begin
        checkCount++;
        $display("[TB] FAIL leftover_%s: got nothing, required event at cycle %0d",
                 kindName(sb[0].kind), sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Directed scenario sequence, all timing hand-planned in absolute cycles.
  initial begin
    fieldTab[0] = {1'b0, 8'h50, 8'h1A, 8'hC3};
    fieldTab[1] = {1'b1, 8'h51, 8'h2B, 8'h5A};
    fieldTab[2] = {1'b0, 8'h52, 8'h3C, 8'h96};
    fieldTab[3] = {1'b1, 8'h53, 8'h4D, 8'h0F};
    reset = 1'b1;
    i2c_done = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_direction[i]              = fieldTab[i][24];
      req_slave_address[8*i +: 8]    = fieldTab[i][23:16];
      req_register_address[8*i +: 8] = fieldTab[i][15:8];
      req_data[8*i +: 8]             = fieldTab[i][7:0];
    end

    goTo(2);
    zeroCheckAt = 2;
    reset = 1'b0;
    goTo(4);

    $display("[TB] single request with done 40 cycles after handshake");
    fork
      applyStimulus(0, 4, 44, 45, 45, 1'b0, 1'b0);
      begin
        goTo(14);
        req_valid[2] = 1'b1;
        goTo(15);
        req_valid[2] = 1'b0;
      end
    join

    $display("[TB] contention from reset");
    resetDut();
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      applyStimulus(k, 48 + 7*k, 53 + 7*k, 54 + 7*k, 54 + 7*k, 1'b0, 1'b0);
    end

    $display("[TB] fairness between requesters 1 and 3");
    resetDut();
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    applyStimulus(1, 78, 83, 84, 84, 1'b0, 1'b1);
    applyStimulus(3, 85, 90, 91, 91, 1'b0, 1'b1);
    applyStimulus(1, 92, 97, 98, 98, 1'b0, 1'b1);
    fork
      applyStimulus(3, 99, 104, 105, 105, 1'b0, 1'b0);
      begin
        goTo(100);
        req_valid[1] = 1'b0;
      end
    join

    $display("[TB] watchdog abort then normal grant");
    applyStimulus(2, 106, -1, -1, 155, 1'b1, 1'b0);
    applyStimulus(0, 156, 161, 162, 162, 1'b0, 1'b0);

    $display("[TB] done edge on the expiry cycle");
    applyStimulus(1, 163, 211, 212, 212, 1'b0, 1'b0);

    $display("[TB] done already high entering wait");
    applyStimulus(3, 213, 214, 262, 262, 1'b1, 1'b0);

    $display("[TB] reset during wait");
    pushEv(0, 263, 4'b0100, 25'h0, 1'b0, 2'b00);
    pushEv(1, 264, 4'b0000, fieldTab[2], 1'b0, 2'b11);
    goTo(263);
    req_valid[2] = 1'b1;
    goTo(264);
    req_valid[2] = 1'b0;
    goTo(268);
    reset = 1'b1;
    goTo(269);
    zeroCheckAt = 269;
    reset = 1'b0;
    goTo(270);
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    applyStimulus(0, 270, 275, 276, 276, 1'b0, 1'b0);
    applyStimulus(1, 277, 282, 283, 283, 1'b0, 1'b0);

    goTo(290);
    finalAt = 290;
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
